// File: rtl/mem_sys_pkg.sv
// Package: mem_sys_pkg
// Shared memory-system widths, nominal access latencies and the latency-queue entry type.
// SEG_W matches the core configuration's SIZE_CORE_LOG value.
package mem_sys_pkg;

  localparam int SEG_W = 4;

  localparam int DELAY_W    = 10;

  localparam int L1_DELAY   = 1;
  localparam int L2_DELAY   = 20;
  localparam int DRAM_DELAY = 400;

  typedef struct packed {
    logic [SEG_W-1:0]   seg;
    logic [DELAY_W-1:0] cnt;
  } lat_entry_t;

endpackage

// File: rtl/mem_lat_slot.sv
// Module: mem_lat_slot
// One latency-queue entry: loads {seg, cnt} on push, then counts the remaining
// latency down to zero and holds there. The zero flag marks the entry as complete.
module mem_lat_slot
  import mem_sys_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  lat_entry_t       load_entry,
  output logic [SEG_W-1:0] seg,
  output logic             zero
);

  lat_entry_t entry;

  // Load a fresh entry on push; otherwise saturating down-count of the remaining latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry <= '0;
    end else if (load) begin
      entry <= load_entry;
    end else if (entry.cnt != '0) begin
      entry.cnt <= entry.cnt - DELAY_W'(1);
    end
  end

  assign seg  = entry.seg;
  assign zero = (entry.cnt == '0);

endmodule

// File: rtl/mem_latency_queue.sv
// Module: mem_latency_queue
// In-order queue that holds each memory request until its looked-up latency has
// elapsed, then hands it back to the SIMD core in issue order. Stalls the lookup
// stage when full.
// Optional build macro MEM_LAT_STATS_EN adds saturating request/stall counters and
// a peak-occupancy register.
module mem_latency_queue
  import mem_sys_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DEPTH_LOG = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [SEG_W-1:0]   req_seg,
  input  logic [DELAY_W-1:0] req_delay,
  output logic               req_ready,
  output logic               stall_out,
  output logic               rsp_valid,
  output logic [SEG_W-1:0]   rsp_seg,
  input  logic               rsp_ready,
  output logic [DEPTH_LOG:0] occupancy
`ifdef MEM_LAT_STATS_EN
  ,
  output logic [31:0]        stat_req,
  output logic [31:0]        stat_stall,
  output logic [DEPTH_LOG:0] stat_maxocc
`endif
);

  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic [DEPTH_LOG:0]   occ_next;
  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;
  lat_entry_t           push_entry;
  logic [SEG_W-1:0]     slot_seg [DEPTH];
  logic [DEPTH-1:0]     slot_zero;

  assign empty      = (occupancy == '0);
  assign full       = (occupancy == (DEPTH_LOG+1)'(DEPTH));
  assign req_ready  = ~full;
  assign stall_out  = full;
  assign rsp_valid  = ~empty & slot_zero[rd_ptr];
  assign rsp_seg    = empty ? '0 : slot_seg[rd_ptr];
  assign push       = req_valid & req_ready;
  assign pop        = rsp_valid & rsp_ready;
  assign push_entry = '{seg: req_seg, cnt: req_delay};

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    mem_lat_slot u_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (push && (wr_ptr == DEPTH_LOG'(i))),
      .load_entry (push_entry),
      .seg        (slot_seg[i]),
      .zero       (slot_zero[i])
    );
  end

  // Occupancy after this edge; a push and a pop in the same cycle cancel out.
  always_comb begin
    occ_next = occupancy;
    case ({push, pop})
      2'b10:   occ_next = occupancy + (DEPTH_LOG+1)'(1);
      2'b01:   occ_next = occupancy - (DEPTH_LOG+1)'(1);
      default: occ_next = occupancy;
    endcase
  end

  // Pointer and occupancy bookkeeping; pointers wrap explicitly from DEPTH-1 back to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      occupancy <= occ_next;
      if (push) begin
        wr_ptr <= (wr_ptr == DEPTH_LOG'(DEPTH-1)) ? '0 : wr_ptr + DEPTH_LOG'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == DEPTH_LOG'(DEPTH-1)) ? '0 : rd_ptr + DEPTH_LOG'(1);
      end
    end
  end

`ifdef MEM_LAT_STATS_EN
  // Saturating push/stall counters and the peak occupancy seen since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_req    <= '0;
      stat_stall  <= '0;
      stat_maxocc <= '0;
    end else begin
      if (push && (stat_req != '1)) begin
        stat_req <= stat_req + 32'd1;
      end
      if (req_valid && !req_ready && (stat_stall != '1)) begin
        stat_stall <= stat_stall + 32'd1;
      end
      if (occ_next > stat_maxocc) begin
        stat_maxocc <= occ_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_latency_queue.sv
// Testbench: tb_mem_latency_queue
// Directed scenarios plus randomized traffic. A reference model (a queue of
// {seg, ready cycle}) is updated from the sampled handshakes; a negedge monitor
// compares every DUT output against it each cycle.
module tb_mem_latency_queue;
  import mem_sys_pkg::*;

  localparam int DEPTH = 8;

  logic               clk       = 1'b0;
  logic               reset     = 1'b1;
  logic               req_valid = 1'b0;
  logic [SEG_W-1:0]   req_seg   = '0;
  logic [DELAY_W-1:0] req_delay = '0;
  logic               rsp_ready = 1'b0;
  logic               req_ready;
  logic               stall_out;
  logic               rsp_valid;
  logic [SEG_W-1:0]   rsp_seg;
  logic [3:0]         occupancy;
`ifdef MEM_LAT_STATS_EN
  logic [31:0]        stat_req;
  logic [31:0]        stat_stall;
  logic [3:0]         stat_maxocc;
`endif

  typedef struct {
    logic [SEG_W-1:0] seg;
    int               ready_at;
  } exp_t;

  exp_t   model_q[$];
  int     checks  = 0;
  int     errors  = 0;
  int     edge_n  = 0;
  bit     armed   = 1'b0;
  longint m_req   = 0;
  longint m_stall = 0;
  int     m_maxocc = 0;

  mem_latency_queue dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_seg     (req_seg),
    .req_delay   (req_delay),
    .req_ready   (req_ready),
    .stall_out   (stall_out),
    .rsp_valid   (rsp_valid),
    .rsp_seg     (rsp_seg),
    .rsp_ready   (rsp_ready),
    .occupancy   (occupancy)
`ifdef MEM_LAT_STATS_EN
    ,
    .stat_req    (stat_req),
    .stat_stall  (stat_stall),
    .stat_maxocc (stat_maxocc)
`endif
  );

  // Free-running clock and edge counter used to timestamp model entries.
  initial forever #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edge_n);
    end
  endtask

  // Drive one cycle of inputs, just after the active edge.
  task automatic applyStimulus(input bit v, input int s, input int d, input bit rr);
    @(posedge clk);
    #1;
    req_valid = v;
    req_seg   = SEG_W'(s);
    req_delay = DELAY_W'(d);
    rsp_ready = rr;
  endtask

  task automatic drainQueue(input int budget);
    int n;
    n = 0;
    while (model_q.size() != 0 && n < budget) begin
      applyStimulus(0, 0, 0, 1);
      n++;
    end
    applyStimulus(0, 0, 0, 1);
    checkOutput("drain_occupancy", occupancy, 0);
  endtask

  // Monitor: compare DUT against the model, then advance the model with this cycle's handshakes.
  always @(negedge clk) begin
    bit               exp_valid;
    bit               accept;
    logic [SEG_W-1:0] exp_seg;
    exp_valid = (model_q.size() > 0) && (model_q[0].ready_at <= edge_n);
    exp_seg   = (model_q.size() > 0) ? model_q[0].seg : '0;
    if (armed) begin
      checkOutput("occupancy", occupancy, model_q.size());
      checkOutput("req_ready", req_ready, model_q.size() != DEPTH);
      checkOutput("stall_out", stall_out, model_q.size() == DEPTH);
      checkOutput("rsp_valid", rsp_valid, exp_valid);
      checkOutput("rsp_seg", rsp_seg, exp_seg);
`ifdef MEM_LAT_STATS_EN
      checkOutput("stat_req", stat_req, m_req);
      checkOutput("stat_stall", stat_stall, m_stall);
      checkOutput("stat_maxocc", stat_maxocc, m_maxocc);
`endif
    end
    if (reset) begin
      model_q.delete();
      m_req    = 0;
      m_stall  = 0;
      m_maxocc = 0;
      armed    = 1'b1;
    end else if (armed) begin
      accept = req_valid && (model_q.size() != DEPTH);
      if (req_valid && !accept) m_stall++;
      if (exp_valid && rsp_ready) void'(model_q.pop_front());
      if (accept) begin
        model_q.push_back('{seg: req_seg, ready_at: edge_n + 1 + int'(req_delay)});
        m_req++;
      end
      if (model_q.size() > m_maxocc) m_maxocc = model_q.size();
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int d;

    reset = 1'b1;
    repeat (2) applyStimulus(0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0);
    checkOutput("reset_occupancy", occupancy, 0);
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_rsp_valid", rsp_valid, 0);

    // Single request, seg 3 with D=5: completes 6 samples after the push cycle.
    applyStimulus(1, 3, 5, 0);
    n = 0;
    do begin
      applyStimulus(0, 0, 0, 0);
      n++;
    end while (!rsp_valid && n < 20);
    checkOutput("single_latency", n, 6);
    checkOutput("single_seg", rsp_seg, 3);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("single_empty", occupancy, 0);

    // D=0: never visible in the push cycle, visible right after the accepting edge.
    applyStimulus(1, 5, 0, 0);
    checkOutput("d0_same_cycle", rsp_valid, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("d0_next_cycle", rsp_valid, 1);
    checkOutput("d0_seg", rsp_seg, 5);
    drainQueue(10);

    // Younger short request waits behind an older DRAM-latency head.
    applyStimulus(1, 1, DRAM_DELAY, 1);
    applyStimulus(1, 2, L1_DELAY, 1);
    drainQueue(DRAM_DELAY + 20);

    // Fill to DEPTH, keep pushing into a full queue, hold back-pressure on a completed head.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, i, L2_DELAY, 0);
    repeat (3) applyStimulus(1, 9, L2_DELAY, 0);
    repeat (30) applyStimulus(0, 0, 0, 0);
    checkOutput("full_occupancy", occupancy, DEPTH);
    checkOutput("full_req_ready", req_ready, 0);
    checkOutput("full_stall_out", stall_out, 1);
    checkOutput("full_head_seg", rsp_seg, 0);
`ifdef MEM_LAT_STATS_EN
    checkOutput("full_stat_maxocc", stat_maxocc, DEPTH);
`endif
    applyStimulus(1, 9, L2_DELAY, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("pop_no_pushthrough", occupancy, DEPTH - 1);
    checkOutput("pop_req_ready", req_ready, 1);
    checkOutput("pop_next_seg", rsp_seg, 1);
    drainQueue(50);

    // Reset with five entries in flight: everything is flushed, nothing comes back.
    for (int i = 0; i < 5; i++) applyStimulus(1, 10 + i, 50, 1);
    applyStimulus(0, 0, 0, 1);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 1);
    reset = 1'b0;
    checkOutput("midreset_occupancy", occupancy, 0);
    checkOutput("midreset_rsp_valid", rsp_valid, 0);
    repeat (60) applyStimulus(0, 0, 0, 1);

    // Randomized traffic with mixed latencies and back-pressure.
    for (int i = 0; i < 1500; i++) begin
      d = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 12));
      applyStimulus($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), d,
                    $urandom_range(0, 9) < 7);
    end
    drainQueue(2000);

    repeat (3) applyStimulus(0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
